// File: rtl/bus_uart_tx.sv
// bus_uart_tx: memory-mapped, FIFO-buffered serial transmitter (8N1).
// Registers: +0x0 TXDATA, +0x4 STATUS, +0x8 CTRL, +0xC BAUDDIV.
// Optional build macro UART_TX_PARITY_EN adds a parity bit (even/odd via CTRL[2]).
module bus_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h40000030,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter logic [15:0] CLKS_PER_BIT = 16'd5208
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRd,
  input  logic        MemWr,
  input  logic [31:0] Addr,
  input  logic [31:0] WData,
  output logic [31:0] RData,
  output logic        tx,
  output logic        IRQ
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  // ---------------- address decode ----------------
  logic [29:0] word_off;
  logic        hit;
  logic [1:0]  reg_sel;
  logic        wr_txdata, wr_status, wr_ctrl, wr_baud;

  assign word_off  = Addr[31:2] - BASE_ADDR[31:2];
  assign hit       = (word_off[29:2] == '0);
  assign reg_sel   = word_off[1:0];
  assign wr_txdata = MemWr && hit && (reg_sel == 2'd0);
  assign wr_status = MemWr && hit && (reg_sel == 2'd1);
  assign wr_ctrl   = MemWr && hit && (reg_sel == 2'd2);
  assign wr_baud   = MemWr && hit && (reg_sel == 2'd3);

  // ---------------- configuration registers ----------------
  logic        tx_en_q, irq_en_q, par_odd;
  logic [15:0] bauddiv_q;
  logic        ovf_q, ovf_d;
  logic        irq_pend_q, irq_pend_d;
  logic        irq_q;

`ifdef UART_TX_PARITY_EN
  logic par_odd_q;
  logic unused_wdata;
  assign unused_wdata = ^{WData[31:16], Addr[1:0]};
  assign par_odd      = par_odd_q;

  // CTRL parity-select bit, only stored when parity support is built in
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       par_odd_q <= 1'b0;
    else if (wr_ctrl) par_odd_q <= WData[2];
  end
`else
  logic unused_wdata;
  assign unused_wdata = ^{WData[31:16], WData[2], Addr[1:0]};
  assign par_odd      = 1'b0;
`endif

  // CTRL enables and BAUDDIV (divisors below 2 are clamped to 2)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_en_q   <= 1'b0;
      irq_en_q  <= 1'b0;
      bauddiv_q <= CLKS_PER_BIT;
    end else begin
      if (wr_ctrl) begin
        tx_en_q  <= WData[0];
        irq_en_q <= WData[1];
      end
      if (wr_baud) bauddiv_q <= (WData[15:0] < 16'd2) ? 16'd2 : WData[15:0];
    end
  end

  // ---------------- TX FIFO ----------------
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          empty, full, push, pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign push  = wr_txdata && !full;

  // FIFO storage write port
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= WData[7:0];
  end

  // FIFO occupancy: simultaneous push and pop leaves the count unchanged
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO pointers and count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  // ---------------- transmitter FSM ----------------
  state_e      state_q, state_d;
  logic [15:0] cnt_q, div_q;
  logic [7:0]  sh_q;
  logic [2:0]  idx_q;
  logic        par_q;
  logic        tx_q, tx_d;
  logic        bit_end, irq_set, busy;

  assign bit_end = (cnt_q == div_q - 16'd1);
  assign busy    = (state_q != S_IDLE);

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (tx_en_q && !empty) state_d = S_START;
      S_START:  if (bit_end) state_d = S_DATA;
      S_DATA:   if (bit_end && (idx_q == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
                end
      S_PARITY: if (bit_end) state_d = S_STOP;
      S_STOP:   if (bit_end) state_d = (tx_en_q && !empty) ? S_START : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM outputs: FIFO pop, next line level, drain interrupt
  always_comb begin
    pop     = 1'b0;
    irq_set = 1'b0;
    tx_d    = tx_q;
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (tx_en_q && !empty) begin
          pop  = 1'b1;
          tx_d = 1'b0;
        end
      end
      S_START: if (bit_end) tx_d = sh_q[0];
      S_DATA: if (bit_end) begin
        if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          tx_d = par_q ^ par_odd;
`else
          tx_d = 1'b1;
`endif
        end else begin
          tx_d = sh_q[1];
        end
      end
      S_PARITY: if (bit_end) tx_d = 1'b1;
      S_STOP: if (bit_end) begin
        if (tx_en_q && !empty) begin
          pop  = 1'b1;
          tx_d = 1'b0;
        end else begin
          tx_d    = 1'b1;
          irq_set = empty;
        end
      end
      default: tx_d = 1'b1;
    endcase
  end

  // Bit timing and shift datapath; the divisor is re-latched at every bit boundary
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      div_q <= CLKS_PER_BIT;
      sh_q  <= '0;
      idx_q <= '0;
      par_q <= 1'b0;
      tx_q  <= 1'b1;
    end else begin
      tx_q <= tx_d;
      if (pop) begin
        sh_q  <= mem_q[rptr_q];
        par_q <= ^mem_q[rptr_q];
        idx_q <= '0;
        cnt_q <= '0;
        div_q <= bauddiv_q;
      end else if (busy) begin
        if (bit_end) begin
          cnt_q <= '0;
          div_q <= bauddiv_q;
          if (state_q == S_DATA) begin
            idx_q <= idx_q + 3'd1;
            sh_q  <= sh_q >> 1;
          end
        end else begin
          cnt_q <= cnt_q + 16'd1;
        end
      end
    end
  end

  // ---------------- status and interrupt ----------------
  always_comb begin
    ovf_d = ovf_q;
    if (wr_txdata && full)         ovf_d = 1'b1;
    else if (wr_status && WData[4]) ovf_d = 1'b0;
    irq_pend_d = irq_pend_q;
    if (irq_set)                   irq_pend_d = 1'b1;
    else if (wr_status && WData[3]) irq_pend_d = 1'b0;
  end

  // Sticky status flags and registered interrupt line
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q      <= 1'b0;
      irq_pend_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      ovf_q      <= ovf_d;
      irq_pend_q <= irq_pend_d;
      irq_q      <= irq_pend_q & irq_en_q;
    end
  end

  // Read mux; zero whenever not selected so it can be OR-merged onto the bus
  always_comb begin
    RData = '0;
    if (MemRd && hit) begin
      case (reg_sel)
        2'd1:    RData = {27'b0, ovf_q, irq_pend_q, busy, full, empty};
        2'd2:    RData = {29'b0, par_odd, irq_en_q, tx_en_q};
        2'd3:    RData = {16'b0, bauddiv_q};
        default: RData = '0;
      endcase
    end
  end

  assign tx  = tx_q;
  assign IRQ = irq_q;

endmodule

// File: tb/tb_bus_uart_tx.sv
// Self-checking bench for bus_uart_tx: randomized frames against a bit-stream model.
module tb_bus_uart_tx;

  localparam logic [31:0] BASE = 32'h40000030;
  localparam logic [31:0] A_TX = BASE + 32'h0;
  localparam logic [31:0] A_ST = BASE + 32'h4;
  localparam logic [31:0] A_CT = BASE + 32'h8;
  localparam logic [31:0] A_BD = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemRd = 1'b0;
  logic        MemWr = 1'b0;
  logic [31:0] Addr = '0;
  logic [31:0] WData = '0;
  logic [31:0] RData;
  logic        tx;
  logic        IRQ;

  bus_uart_tx #(
    .BASE_ADDR   (BASE),
    .FIFO_DEPTH  (8),
    .CLKS_PER_BIT(16'd5208)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .MemRd(MemRd),
    .MemWr(MemWr),
    .Addr (Addr),
    .WData(WData),
    .RData(RData),
    .tx   (tx),
    .IRQ  (IRQ)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // line and IRQ sampled at the negedge following each rising edge
  int unsigned cyc_n = 0;
  logic        txlog  [0:65535];
  logic        irqlog [0:65535];
  always @(posedge clk) cyc_n = cyc_n + 1;
  always @(negedge clk) begin
    txlog[cyc_n[15:0]]  = tx;
    irqlog[cyc_n[15:0]] = IRQ;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, output int unsigned edge_n);
    @(negedge clk);
    Addr = a; WData = d; MemWr = 1'b1;
    @(posedge clk);
    #1;
    edge_n = cyc_n;
    MemWr = 1'b0; Addr = '0; WData = '0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    int unsigned e;
    bus_write(a, d, e);
  endtask

  // write so that it is sampled exactly at rising edge number e
  task automatic bus_write_at(input int unsigned e, input logic [31:0] a, input logic [31:0] d);
    int unsigned got_e;
    while (cyc_n < e - 1) begin
      @(posedge clk);
      #1;
    end
    bus_write(a, d, got_e);
    chk("write_edge", got_e, e);
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    Addr = a; MemRd = 1'b1;
    #1;
    d = RData;
    MemRd = 1'b0; Addr = '0;
  endtask

  task automatic wait_logged(input int unsigned e);
    int unsigned guard = 0;
    while (cyc_n <= e && guard < 70000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (cyc_n <= e) chk("wait_timeout", cyc_n, e + 1);
  endtask

  // ---------------- reference model: expected line level per cycle ----------------
  logic        exp_q [$];
  logic [7:0]  tx_bytes [$];

  // frame = start(0), 8 data LSB first, [parity], stop(1); first nfast bits last d1 clocks, rest d2
  task automatic add_frame(input logic [7:0] b, input int unsigned d1, input int unsigned nfast,
                           input int unsigned d2, input logic odd);
    logic bits [$];
    bits.push_back(1'b0);
    for (int unsigned i = 0; i < 8; i++) bits.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
    bits.push_back((^b) ^ odd);
`endif
    bits.push_back(1'b1);
    for (int unsigned i = 0; i < bits.size(); i++) begin
      int unsigned dur = (i < nfast) ? d1 : d2;
      repeat (dur) exp_q.push_back(bits[i]);
    end
  endtask

  task automatic check_stream(input int unsigned first_edge);
    wait_logged(first_edge + exp_q.size());
    for (int unsigned i = 0; i < exp_q.size(); i++)
      chk($sformatf("tx[%0d]", i), txlog[(first_edge + i) % 65536], exp_q[i]);
  endtask

  function automatic logic [31:0] ctrl_exp(input logic odd, input logic ien, input logic ten);
`ifdef UART_TX_PARITY_EN
    return {29'b0, odd, ien, ten};
`else
    return {29'b0, 1'b0, ien, ten};
`endif
  endfunction

  // load tx_bytes with tx disabled, check status, enable and check the whole stream
  task automatic run_round(input int unsigned dwr, input logic ien, input logic odd);
    logic [31:0]  rd;
    int unsigned  w, d, k, t, n;
    d = (dwr < 2) ? 2 : dwr;
    n = tx_bytes.size();
    k = (n > 8) ? 8 : n;
    wr(A_CT, ctrl_exp(odd, ien, 1'b0) | {29'b0, odd, 2'b0});
    wr(A_BD, dwr);
    foreach (tx_bytes[j]) wr(A_TX, {24'b0, tx_bytes[j]});
    bus_read(A_ST, rd);
    chk("status_loaded", rd, ((n > 8) ? 32'h10 : 32'h0) | ((k == 8) ? 32'h2 : 32'h0));
    bus_read(A_BD, rd);
    chk("bauddiv_rd", rd, d);
    bus_read(A_CT, rd);
    chk("ctrl_rd", rd, ctrl_exp(odd, ien, 1'b0));
    exp_q.delete();
    for (int unsigned j = 0; j < k; j++) add_frame(tx_bytes[j], d, 99, d, odd);
    t = exp_q.size();
    for (int unsigned j = 0; j < 2 * d; j++) exp_q.push_back(1'b1);
    bus_write(A_CT, ctrl_exp(odd, ien, 1'b1) | {29'b0, odd, 2'b0}, w);
    check_stream(w + 1);
    wait_logged(w + t + 2);
    chk("irq_pre", irqlog[(w + t + 1) % 65536], 1'b0);
    chk("irq_post", irqlog[(w + t + 2) % 65536], ien);
    bus_read(A_ST, rd);
    chk("status_done", rd, 32'h09 | ((n > 8) ? 32'h10 : 32'h0));
    wr(A_ST, 32'h18);
    repeat (2) @(posedge clk);
    #1;
    chk("irq_cleared", IRQ, 1'b0);
    bus_read(A_ST, rd);
    chk("status_clr", rd, 32'h01);
  endtask

  initial begin
    logic [31:0] rd;
    int unsigned w;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", tx, 1'b1);
    chk("rst_irq", IRQ, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    bus_read(A_ST, rd);      chk("rst_status", rd, 32'h1);
    bus_read(A_BD, rd);      chk("rst_baud", rd, 32'd5208);
    bus_read(A_CT, rd);      chk("rst_ctrl", rd, 32'h0);
    bus_read(A_TX, rd);      chk("txdata_rd", rd, 32'h0);
    bus_read(BASE + 32'h10, rd); chk("unsel_hi", rd, 32'h0);
    bus_read(BASE - 32'h4, rd);  chk("unsel_lo", rd, 32'h0);
    @(negedge clk);
    Addr = A_ST; #1; chk("no_memrd", RData, 32'h0); Addr = '0;

    // single byte, then back-to-back with IRQ enabled
    tx_bytes = '{8'h55};
    run_round(4, 1'b0, 1'b0);
    tx_bytes = '{8'hA5, 8'h3C};
    run_round(4, 1'b1, 1'b0);
    // overflow: 9 bytes, only the first 8 transmitted in order
    tx_bytes.delete();
    for (int unsigned j = 0; j < 9; j++) tx_bytes.push_back(8'(j * 37 + 1));
    run_round(2, 1'b1, 1'b1);
    // randomized rounds
    for (int unsigned r = 0; r < 5; r++) begin
      int unsigned n = $urandom_range(1, 10);
      tx_bytes.delete();
      for (int unsigned j = 0; j < n; j++) tx_bytes.push_back(8'($urandom));
      run_round($urandom_range(0, 6), 1'($urandom), 1'($urandom));
    end

    // mid-frame: divisor change during bit 3 and tx disable
    wr(A_CT, 32'h0);
    wr(A_BD, 32'd4);
    wr(A_TX, 32'h96);
    wr(A_TX, 32'h5A);
    exp_q.delete();
    add_frame(8'h96, 4, 4, 8, 1'b0);
    for (int unsigned j = 0; j < 16; j++) exp_q.push_back(1'b1);
    bus_write(A_CT, 32'h1, w);
    bus_write_at(w + 14, A_BD, 32'd8);
    bus_write_at(w + 15, A_CT, 32'h0);
    check_stream(w + 1);
    bus_read(A_ST, rd);
    chk("mid_status", rd, 32'h0);

    // reset asserted mid-frame on the remaining byte 0x5A
    bus_write(A_BD, 32'd4, w);
    bus_write(A_CT, 32'h1, w);
    wait_logged(w + 6);
    chk("pre_rst_tx", txlog[(w + 6) % 65536], 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("async_rst_tx", tx, 1'b1);
    bus_read(A_ST, rd);      chk("rst_mid_status", rd, 32'h1);
    @(negedge clk);
    reset = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("post_rst_tx", tx, 1'b1);
    chk("post_rst_irq", IRQ, 1'b0);
    bus_read(A_ST, rd);      chk("post_rst_status", rd, 32'h1);
    bus_read(A_BD, rd);      chk("post_rst_baud", rd, 32'd5208);
    bus_read(A_CT, rd);      chk("post_rst_ctrl", rd, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
